// File: rtl/multi_ring_counter_pkg.sv
// Shared definitions for the multi-mode ring/Johnson counter:
// mode encodings and the per-mode seed value.
package multi_ring_counter_pkg;

  typedef enum logic [1:0] {
    RC_RING    = 2'b00,  // one-hot rotate
    RC_JOHNSON = 2'b01,  // twisted-ring (Johnson)
    RC_RING_N  = 2'b10,  // one-cold rotate
    RC_HOLD    = 2'b11   // freeze
  } rc_mode_e;

  // Seed returned at full 32-bit width; callers truncate to their WIDTH.
  // The one-cold pattern truncates to "only bit0 clear" at any width.
  // Hold has no sequence of its own, so it reports the one-hot seed.
  function automatic logic [31:0] rc_seed(rc_mode_e m);
    logic [31:0] s;
    case (m)
      RC_JOHNSON: s = 32'h0000_0000;
      RC_RING_N:  s = 32'hFFFF_FFFE;
      default:    s = 32'h0000_0001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rc_legal_check.sv
// Combinational legality check of the counter state against the
// sequence selected by mode.
module rc_legal_check
  import multi_ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [1:0]       mode,
  output logic             legal
);

  int ones;
  int edges;

  // Count set bits and adjacent-bit transitions, then judge by mode.
  always_comb begin
    ones  = $countones(count);
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + int'(count[i] ^ count[i+1]);
    end
    case (rc_mode_e'(mode))
      RC_RING:    legal = (ones == 1);
      RC_RING_N:  legal = (ones == WIDTH - 1);
      RC_JOHNSON: legal = (edges <= 1);
      default:    legal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_ring_counter.sv
// Multi-mode shift counter: one-hot ring, Johnson, one-cold ring or hold,
// either direction, with parallel load and optional illegal-state repair.
// count, wrap and err are all registered.
module multi_ring_counter
  import multi_ring_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] seed;
  logic             legal;
  logic             active;

  // A step (or repair) only happens when enabled and not in hold.
  assign active = en && (mode != RC_HOLD);
  assign seed   = WIDTH'(rc_seed(rc_mode_e'(mode)));

  generate
    if (CHECK_EN) begin : g_check
      rc_legal_check #(.WIDTH(WIDTH)) u_legal (
        .count (count),
        .mode  (mode),
        .legal (legal)
      );
    end else begin : g_no_check
      assign legal = 1'b1;
    end
  endgenerate

  // Next state for a normal step: plain rotate for rings, inverted
  // feedback for Johnson; dir=0 shifts toward the MSB.
  always_comb begin
    next_count = count;
    if (mode == RC_JOHNSON) begin
      next_count = dir ? {~count[0], count[WIDTH-1:1]}
                       : {count[WIDTH-2:0], ~count[WIDTH-1]};
    end else begin
      next_count = dir ? {count[0], count[WIDTH-1:1]}
                       : {count[WIDTH-2:0], count[WIDTH-1]};
    end
  end

  // State update with priority load > repair > step > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= WIDTH'(1);
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (active && !legal) begin
      count <= seed;
      wrap  <= 1'b0;
      err   <= 1'b1;
    end else if (active) begin
      count <= next_count;
      wrap  <= (next_count == seed);
      err   <= 1'b0;
    end else begin
      wrap  <= 1'b0;
      err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_ring_counter.sv
// Directed self-checking bench for multi_ring_counter at WIDTH=4.
// A second instance with the legality check removed shares all inputs.
module tb_multi_ring_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap;
  logic         err;
  logic [W-1:0] count_nc;
  logic         wrap_nc;
  logic         err_nc;

  int n_cmp;
  int n_bad;

  // Expected {wrap, count} per clock for sequence runs.
  logic [W:0] exp_q[$];

  multi_ring_counter #(.WIDTH(W), .CHECK_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .err      (err)
  );

  multi_ring_counter #(.WIDTH(W), .CHECK_EN(1'b0)) dut_nc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count_nc),
    .wrap     (wrap_nc),
    .err      (err_nc)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step the clock once per queued entry and check count and wrap.
  task automatic run_queue(input string tag);
    logic [W:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check_eq({tag, "_count"}, 32'(count), 32'(e[W-1:0]));
      check_eq({tag, "_wrap"},  32'(wrap),  32'(e[W]));
      check_eq({tag, "_err"},   32'(err),   32'h0);
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    en       = 1'b0;
    mode     = 2'b00;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_count", 32'(count), 32'h1);
    check_eq("rst_wrap",  32'(wrap),  32'h0);
    check_eq("rst_err",   32'(err),   32'h0);

    // Deassertion alone produces no pulse
    rst = 1'b0;
    tick();
    check_eq("rel_count", 32'(count), 32'h1);
    check_eq("rel_wrap",  32'(wrap),  32'h0);
    check_eq("rel_err",   32'(err),   32'h0);

    // One-hot left from seed
    en = 1'b1;
    exp_q.push_back(5'b0_0010);
    exp_q.push_back(5'b0_0100);
    exp_q.push_back(5'b0_1000);
    exp_q.push_back(5'b1_0001);
    run_queue("hot_left");

    // Johnson left from 0000, full period
    en   = 1'b0;
    mode = 2'b01;
    do_load(4'b0000);
    check_eq("jl_load_count", 32'(count), 32'h0);
    check_eq("jl_load_wrap",  32'(wrap),  32'h0);
    en = 1'b1;
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_0011);
    exp_q.push_back(5'b0_0111);
    exp_q.push_back(5'b0_1111);
    exp_q.push_back(5'b0_1110);
    exp_q.push_back(5'b0_1100);
    exp_q.push_back(5'b0_1000);
    exp_q.push_back(5'b1_0000);
    run_queue("john_left");

    // Johnson right, first two steps
    dir = 1'b1;
    exp_q.push_back(5'b0_1000);
    exp_q.push_back(5'b0_1100);
    run_queue("john_right");

    // One-cold right after load
    mode = 2'b10;
    en   = 1'b0;
    do_load(4'b1110);
    check_eq("cold_load", 32'(count), 32'hE);
    en = 1'b1;
    exp_q.push_back(5'b0_0111);
    exp_q.push_back(5'b0_1011);
    exp_q.push_back(5'b0_1101);
    exp_q.push_back(5'b1_1110);
    run_queue("cold_right");

    // Illegal one-hot state: repaired with check, rotated without
    mode = 2'b00;
    dir  = 1'b0;
    en   = 1'b0;
    do_load(4'b0110);
    check_eq("ill_load", 32'(count), 32'h6);
    en = 1'b1;
    tick();
    check_eq("ill_count",    32'(count),    32'h1);
    check_eq("ill_err",      32'(err),      32'h1);
    check_eq("ill_wrap",     32'(wrap),     32'h0);
    check_eq("ill_nc_count", 32'(count_nc), 32'hC);
    check_eq("ill_nc_err",   32'(err_nc),   32'h0);
    tick();
    check_eq("ill_next_count", 32'(count), 32'h2);
    check_eq("ill_err_clear",  32'(err),   32'h0);

    // Load wins over en on the same edge
    do_load(4'b0100);
    check_eq("ld_en_count", 32'(count), 32'h4);
    check_eq("ld_en_err",   32'(err),   32'h0);
    check_eq("ld_en_wrap",  32'(wrap),  32'h0);

    // Hold with en=0, then with mode=11
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_en", 32'(count), 32'h4);
    end
    en   = 1'b1;
    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_mode",     32'(count), 32'h4);
      check_eq("hold_mode_err", 32'(err),   32'h0);
    end

    // Switching to Johnson with 0100 (two transitions) repairs to 0000
    mode = 2'b01;
    tick();
    check_eq("sw_john_count", 32'(count), 32'h0);
    check_eq("sw_john_err",   32'(err),   32'h1);
    check_eq("sw_john_wrap",  32'(wrap),  32'h0);

    // Johnson running to 0111, then asynchronous reset between edges
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_0011);
    exp_q.push_back(5'b0_0111);
    run_queue("john_pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_count", 32'(count), 32'h1);
    check_eq("async_rst_wrap",  32'(wrap),  32'h0);
    check_eq("async_rst_err",   32'(err),   32'h0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_count", 32'(count), 32'h3);
    check_eq("post_rst_err",   32'(err),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
